// File: rtl/bip_run_ctrl_if.sv
// Host-side bundle for bip_run_ctrl: run-control pulses, CPU observation, status outputs.
interface bip_run_ctrl_if #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned CNT_BITS = 32
);
    logic                i_start;
    logic                i_abort;
    logic                i_clear;
    logic                i_step_mode;
    logic                i_step;
    logic                i_halt;
    logic [BITS-1:0]     i_data;
    logic                o_cpu_reset;
    logic                o_cpu_enable;
    logic                o_busy;
    logic                o_done;
    logic                o_timeout;
    logic [CNT_BITS-1:0] o_cycles;
    logic [BITS-1:0]     o_result;

    // Host side: drives control pulses and CPU flags, observes status
    modport master (
        output i_start, i_abort, i_clear, i_step_mode, i_step, i_halt, i_data,
        input  o_cpu_reset, o_cpu_enable, o_busy, o_done, o_timeout, o_cycles, o_result
    );

    // Controller side
    modport slave (
        input  i_start, i_abort, i_clear, i_step_mode, i_step, i_halt, i_data,
        output o_cpu_reset, o_cpu_enable, o_busy, o_done, o_timeout, o_cycles, o_result
    );
endinterface

// File: rtl/bip_run_ctrl.sv
// Run-control and result-capture unit for the BIP CPU: reset window, free/step run,
// enabled-cycle counting, halt capture and cycle timeout.
module bip_run_ctrl #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned CNT_BITS   = 32,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 250000
) (
    input  logic          i_clock,
    input  logic          i_reset,
    bip_run_ctrl_if.slave io_bus
);
    localparam int unsigned          RC_W    = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_BITS-1:0]  TMO_VAL = CNT_BITS'(TIMEOUT);
    localparam bit                   TMO_EN  = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    state_t              r_state,      w_state;
    logic [RC_W-1:0]     r_rst_cnt,    w_rst_cnt;
    logic                r_step_mode,  w_step_mode;
    logic                r_cpu_reset,  w_cpu_reset;
    logic                r_cpu_enable, w_cpu_enable;
    logic                r_busy,       w_busy;
    logic                r_done,       w_done;
    logic                r_timeout,    w_timeout;
    logic [CNT_BITS-1:0] r_cycles,     w_cycles;
    logic [BITS-1:0]     r_result,     w_result;
    logic                w_limit;

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_rst_cnt    <= '0;
            r_step_mode  <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cycles     <= '0;
            r_result     <= '0;
        end else begin
            r_state      <= w_state;
            r_rst_cnt    <= w_rst_cnt;
            r_step_mode  <= w_step_mode;
            r_cpu_reset  <= w_cpu_reset;
            r_cpu_enable <= w_cpu_enable;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_timeout    <= w_timeout;
            r_cycles     <= w_cycles;
            r_result     <= w_result;
        end
    end

    // Next-state and next-output logic; pulse priority abort > start > clear > step
    always_comb begin
        w_state      = r_state;
        w_rst_cnt    = r_rst_cnt;
        w_step_mode  = r_step_mode;
        w_cpu_enable = 1'b0;
        w_done       = r_done;
        w_timeout    = r_timeout;
        w_result     = r_result;
        // every enabled CPU cycle is counted, saturating at all-ones
        w_cycles     = (r_cpu_enable && (r_cycles != '1)) ? r_cycles + CNT_BITS'(1) : r_cycles;
        // no further enable once the count reaches the limit; the limit itself is acted on next cycle
        w_limit      = TMO_EN && (w_cycles == TMO_VAL);

        case (r_state)
            S_IDLE: begin
                if (io_bus.i_start) begin
                    w_state = S_RESET;
                end
            end
            S_RESET: begin
                if (io_bus.i_abort) begin
                    w_state = S_IDLE;
                end else if (!io_bus.i_start) begin
                    w_step_mode = io_bus.i_step_mode;
                    w_rst_cnt   = r_rst_cnt - RC_W'(1);
                    if (w_rst_cnt == '0) begin
                        w_state      = S_RUN;
                        w_cpu_enable = !io_bus.i_step_mode;
                    end
                end
            end
            S_RUN: begin
                if (io_bus.i_abort) begin
                    w_state = S_IDLE;
                end else if (io_bus.i_start) begin
                    w_state = S_RESET;
                end else if (io_bus.i_halt) begin
                    w_state  = S_DONE;
                    w_done   = 1'b1;
                    w_result = io_bus.i_data;
                end else if (TMO_EN && (r_cycles == TMO_VAL)) begin
                    w_state   = S_TMO;
                    w_timeout = 1'b1;
                end else if (r_step_mode) begin
                    w_cpu_enable = io_bus.i_step && !r_cpu_enable && !w_limit;
                end else begin
                    w_cpu_enable = !w_limit;
                end
            end
            S_DONE, S_TMO: begin
                if (io_bus.i_start) begin
                    w_state = S_RESET;
                end else if (io_bus.i_clear) begin
                    w_state   = S_IDLE;
                    w_done    = 1'b0;
                    w_timeout = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // a start accepted in any state opens a fresh reset window with cleared run status
        if (io_bus.i_start && !(io_bus.i_abort && (r_state == S_RESET || r_state == S_RUN))) begin
            w_state      = S_RESET;
            w_rst_cnt    = RC_W'(RST_CYCLES);
            w_cycles     = '0;
            w_done       = 1'b0;
            w_timeout    = 1'b0;
            w_cpu_enable = 1'b0;
        end

        w_cpu_reset = (w_state == S_IDLE) || (w_state == S_RESET);
        w_busy      = (w_state == S_RESET) || (w_state == S_RUN);
    end

    assign io_bus.o_cpu_reset  = r_cpu_reset;
    assign io_bus.o_cpu_enable = r_cpu_enable;
    assign io_bus.o_busy       = r_busy;
    assign io_bus.o_done       = r_done;
    assign io_bus.o_timeout    = r_timeout;
    assign io_bus.o_cycles     = r_cycles;
    assign io_bus.o_result     = r_result;
endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed + randomized bench for bip_run_ctrl with a run-level expectation model.
module tb_bip_run_ctrl;
    localparam int unsigned BITS       = 16;
    localparam int unsigned CNT_BITS   = 32;
    localparam int unsigned RST_CYCLES = 4;
    localparam int unsigned TIMEOUT    = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bip_run_ctrl_if #(.BITS(BITS), .CNT_BITS(CNT_BITS)) bus ();

    bip_run_ctrl #(
        .BITS(BITS), .CNT_BITS(CNT_BITS), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .io_bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [BITS-1:0] m_result;
    int ob_en, ob_run, ob_max;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit e_rst, input bit e_en, input bit e_busy,
                              input bit e_done, input bit e_tmo, input int e_cyc,
                              input logic [BITS-1:0] e_res);
        chk({tag, ".cpu_reset"}, 64'(bus.o_cpu_reset),  64'(e_rst));
        chk({tag, ".enable"},    64'(bus.o_cpu_enable), 64'(e_en));
        chk({tag, ".busy"},      64'(bus.o_busy),       64'(e_busy));
        chk({tag, ".done"},      64'(bus.o_done),       64'(e_done));
        chk({tag, ".timeout"},   64'(bus.o_timeout),    64'(e_tmo));
        chk({tag, ".cycles"},    64'(bus.o_cycles),     64'(e_cyc));
        chk({tag, ".result"},    64'(bus.o_result),     64'(e_res));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Record enable activity at the current sample point
    task automatic observe();
        if (bus.o_cpu_enable) begin
            ob_en++;
            ob_run++;
            if (ob_run > ob_max) ob_max = ob_run;
        end else begin
            ob_run = 0;
        end
    endtask

    // Start pulse, check cleared status, then measure the reset window
    task automatic start_run(input string tag, input bit step_mode);
        int rc;
        bus.i_step_mode = step_mode;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk_status({tag, ".start"}, 1, 0, 1, 0, 0, 0, m_result);
        rc = 0;
        while (bus.o_busy && bus.o_cpu_reset && rc < 20) begin
            rc++;
            tick();
        end
        chk({tag, ".rstwin"}, 64'(rc), 64'(RST_CYCLES));
        // mode is only sampled during the reset window
        bus.i_step_mode = 1'($urandom);
    endtask

    // Free run; mode 0: halt in enabled cycle k, 1: halt when count sits at TIMEOUT, 2: abort at k
    task automatic run_free(input string tag, input int k, input int mode, input logic [BITS-1:0] d);
        int guard;
        int e_cyc;
        start_run(tag, 1'b0);
        ob_en = 0; ob_run = 0; ob_max = 0;
        guard = 0;
        while (bus.o_busy && guard < 200) begin
            guard++;
            observe();
            bus.i_data = BITS'($urandom);
            if (mode == 0 && bus.o_cpu_enable && ob_en == k) begin
                bus.i_halt = 1'b1; bus.i_data = d;
            end
            if (mode == 1 && bus.o_cycles == CNT_BITS'(TIMEOUT)) begin
                bus.i_halt = 1'b1; bus.i_data = d;
            end
            if (mode == 2 && bus.o_cpu_enable && ob_en == k) bus.i_abort = 1'b1;
            tick();
            bus.i_halt  = 1'b0;
            bus.i_abort = 1'b0;
        end
        chk({tag, ".ended"}, 64'(guard < 200), 64'(1));
        if (mode == 2) begin
            chk({tag, ".enables"}, 64'(ob_en), 64'(k));
            chk_status(tag, 1, 0, 0, 0, 0, k, m_result);
        end else if (mode == 1 || k <= int'(TIMEOUT)) begin
            e_cyc = (mode == 1) ? int'(TIMEOUT) : k;
            m_result = d;
            chk({tag, ".enables"}, 64'(ob_en), 64'(e_cyc));
            chk_status(tag, 0, 0, 0, 1, 0, e_cyc, m_result);
        end else begin
            chk({tag, ".enables"}, 64'(ob_en), 64'(TIMEOUT));
            chk_status(tag, 0, 0, 0, 0, 1, int'(TIMEOUT), m_result);
        end
    endtask

    // Step-mode run: nsteps granted pulses (optionally one back-to-back extra), then halt
    task automatic run_step(input string tag, input int nsteps, input bit b2b, input logic [BITS-1:0] d);
        start_run(tag, 1'b1);
        ob_en = 0; ob_run = 0; ob_max = 0;
        for (int s = 0; s < nsteps; s++) begin
            repeat ($urandom_range(1, 3)) begin
                observe(); bus.i_data = BITS'($urandom); tick();
            end
            observe();
            bus.i_step = 1'b1;
            tick();
            bus.i_step = 1'b0;
            if (b2b && s == 0) begin
                observe();
                bus.i_step = 1'b1;
                tick();
                bus.i_step = 1'b0;
            end
        end
        repeat (3) begin
            observe(); tick();
        end
        observe();
        bus.i_data = d;
        bus.i_halt = 1'b1;
        tick();
        bus.i_halt = 1'b0;
        m_result = d;
        chk({tag, ".enables"}, 64'(ob_en), 64'(nsteps));
        chk({tag, ".pulsewidth"}, 64'(ob_max), 64'(1));
        chk_status(tag, 0, 0, 0, 1, 0, nsteps, m_result);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_clear = 1'b0;
        bus.i_step_mode = 1'b0; bus.i_step = 1'b0; bus.i_halt = 1'b0;
        bus.i_data = '0;
        m_result = '0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk_status("por", 1, 0, 0, 0, 0, 0, '0);
        rst_n = 1'b1;
        tick();
        chk_status("idle", 1, 0, 0, 0, 0, 0, '0);

        run_free("free", 40, 0, 16'h00A5);

        // abort is ignored once the run has ended
        bus.i_abort = 1'b1; tick(); bus.i_abort = 1'b0;
        chk_status("abort_in_done", 0, 0, 0, 1, 0, 40, m_result);

        run_free("tmo", 1000, 0, 16'h1234);

        bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
        chk_status("clear", 1, 0, 0, 0, 0, int'(TIMEOUT), m_result);

        run_step("step", 3, 1'b0, 16'hBEEF);
        run_free("race", 0, 1, 16'h5A5A);
        run_free("halt_at_limit", int'(TIMEOUT), 0, 16'h0F0F);
        run_free("abort", 20, 2, 16'h7777);
        run_step("step_b2b", 4, 1'b1, 16'hC3C3);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_step($sformatf("rstep%0d", i), int'($urandom_range(1, 8)),
                         1'($urandom_range(0, 1)), BITS'($urandom));
            else
                run_free($sformatf("rfree%0d", i), int'($urandom_range(1, 70)), 0,
                         BITS'($urandom));
        end

        // asynchronous reset in the middle of a free run
        bus.i_step_mode = 1'b0;
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
        repeat (12) tick();
        #2 rst_n = 1'b0;
        #1;
        m_result = '0;
        chk_status("arst", 1, 0, 0, 0, 0, 0, m_result);
        tick();
        chk_status("arst_hold", 1, 0, 0, 0, 0, 0, m_result);
        rst_n = 1'b1;
        tick();
        run_free("post_rst", 5, 0, 16'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
